apu_frame_sequencer: RTL and testbench

- Timing and lifecycle controller for the four PSG channels (square1, square2, wave, noise) of the GBA audio block.
- Divides clk_100 into the 512 Hz frame sequencer.
- Issues single-cycle length/sweep/envelope tick strobes.
- Owns the four channel length counters, channel restart pulses and the channel-active status that feeds the NR52[3:0] readback and the mixer gating.
- Sits between the MMIO register file and the channel/mixer instances in the audio top.

---
 rtl/apu_seq_pkg.sv | 13 +
 rtl/apu_length_counter.sv | 32 +++
 rtl/apu_frame_sequencer.sv | 85 ++++++++
 tb/tb_apu_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_seq_pkg.sv
// apu_seq_pkg: shared constants for the APU frame sequencer and its length counters.
package apu_seq_pkg;
  localparam int LEN_MAX_SQ = 64;
  localparam int LEN_MAX_WAVE = 256;
  // Bit s set means the strobe fires when step s completes.
  localparam logic [7:0] LEN_STEPS = 8'b01010101;
  localparam logic [7:0] SWEEP_STEPS = 8'b01000100;
  localparam logic [7:0] ENV_STEPS = 8'b10000000;
  localparam int CH_SQ1 = 0;
  localparam int CH_SQ2 = 1;
  localparam int CH_WAVE = 2;
  localparam int CH_NOISE = 3;
endpackage

// File: rtl/apu_length_counter.sv
// apu_length_counter: one channel's length counter; expire flags the decrement that reaches zero.
module apu_length_counter #(
  parameter int W = 7,
  parameter int VW = 6,
  parameter int MAX = 64
) (
  input  logic          clk_100,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [VW-1:0] value,
  input  logic          trig,
  input  logic          tick,
  input  logic          en,
  output logic          expire
);
  logic [W-1:0] cnt_q, cnt_d;
  logic dec;
  // A load or trigger in the tick cycle takes precedence over the decrement.
  assign dec = !clr && !load && !trig && tick && en && cnt_q != '0;
  assign expire = dec && cnt_q == W'(1);
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (load) cnt_d = W'(MAX) - W'(value);
    else if (trig) cnt_d = (cnt_q == '0) ? W'(MAX) : cnt_q;
    else if (dec) cnt_d = cnt_q - W'(1);
  end
  always_ff @(posedge clk_100 or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: 512 Hz frame sequencer, tick strobes, length counters and channel-active status.
module apu_frame_sequencer
  import apu_seq_pkg::*;
#(
  parameter int DIV = 195312,
  parameter int LEN_W_SQ = 7,
  parameter int LEN_W_WAVE = 9
) (
  input  logic       clk_100,
  input  logic       reset,
  input  logic       apu_en,
  input  logic [3:0] trig,
  input  logic [3:0] len_wr,
  input  logic [5:0] len_val_sq1,
  input  logic [5:0] len_val_sq2,
  input  logic [7:0] len_val_wave,
  input  logic [5:0] len_val_noise,
  input  logic [3:0] len_en,
  input  logic [3:0] dac_on,
  input  logic       sweep_ovf,
  output logic       tick_len,
  output logic       tick_sweep,
  output logic       tick_env,
  output logic [2:0] step,
  output logic [3:0] restart,
  output logic [3:0] ch_active
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0] step_q, step_d;
  logic tick_len_q, tick_len_d, tick_sweep_q, tick_sweep_d, tick_env_q, tick_env_d;
  logic [3:0] restart_q, restart_d, active_q, active_d, expire;
  logic wrap, clr;
  assign clr = !apu_en;
  assign wrap = apu_en && presc_q == PW'(DIV - 1);
  always_comb begin
    presc_d = (clr || wrap) ? '0 : presc_q + PW'(1);
    step_d = clr ? '0 : step_q + 3'(wrap);
    tick_len_d = wrap && LEN_STEPS[step_q];
    tick_sweep_d = wrap && SWEEP_STEPS[step_q];
    tick_env_d = wrap && ENV_STEPS[step_q];
    restart_d = clr ? '0 : trig;
    active_d = active_q;
    // A DAC that is off wins over a trigger landing in the same cycle.
    for (int i = 0; i < 4; i++)
      active_d[i] = (clr || !dac_on[i] || expire[i] || (i == CH_SQ1 && sweep_ovf)) ? 1'b0 :
                    trig[i] ? 1'b1 : active_q[i];
  end
  always_ff @(posedge clk_100 or posedge reset)
    if (reset) begin
      presc_q <= '0;
      step_q <= '0;
      tick_len_q <= 1'b0;
      tick_sweep_q <= 1'b0;
      tick_env_q <= 1'b0;
      restart_q <= '0;
      active_q <= '0;
    end else begin
      presc_q <= presc_d;
      step_q <= step_d;
      tick_len_q <= tick_len_d;
      tick_sweep_q <= tick_sweep_d;
      tick_env_q <= tick_env_d;
      restart_q <= restart_d;
      active_q <= active_d;
    end
  apu_length_counter #(.W(LEN_W_SQ), .VW(6), .MAX(LEN_MAX_SQ)) u_len_sq1 (
    .clk_100, .reset, .clr, .load(len_wr[CH_SQ1]), .value(len_val_sq1), .trig(trig[CH_SQ1]),
    .tick(tick_len_q), .en(len_en[CH_SQ1]), .expire(expire[CH_SQ1]));
  apu_length_counter #(.W(LEN_W_SQ), .VW(6), .MAX(LEN_MAX_SQ)) u_len_sq2 (
    .clk_100, .reset, .clr, .load(len_wr[CH_SQ2]), .value(len_val_sq2), .trig(trig[CH_SQ2]),
    .tick(tick_len_q), .en(len_en[CH_SQ2]), .expire(expire[CH_SQ2]));
  apu_length_counter #(.W(LEN_W_WAVE), .VW(8), .MAX(LEN_MAX_WAVE)) u_len_wave (
    .clk_100, .reset, .clr, .load(len_wr[CH_WAVE]), .value(len_val_wave), .trig(trig[CH_WAVE]),
    .tick(tick_len_q), .en(len_en[CH_WAVE]), .expire(expire[CH_WAVE]));
  apu_length_counter #(.W(LEN_W_SQ), .VW(6), .MAX(LEN_MAX_SQ)) u_len_noise (
    .clk_100, .reset, .clr, .load(len_wr[CH_NOISE]), .value(len_val_noise), .trig(trig[CH_NOISE]),
    .tick(tick_len_q), .en(len_en[CH_NOISE]), .expire(expire[CH_NOISE]));
  assign tick_len = tick_len_q;
  assign tick_sweep = tick_sweep_q;
  assign tick_env = tick_env_q;
  assign step = step_q;
  assign restart = restart_q;
  assign ch_active = active_q;
endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer: directed scenarios plus random stimulus against a count-based reference model.
module tb_apu_frame_sequencer;
  localparam int DIV = 4;
  logic clk_100 = 1'b0;
  logic reset, apu_en, sweep_ovf;
  logic [3:0] trig, len_wr, len_en, dac_on;
  logic [5:0] len_val_sq1, len_val_sq2, len_val_noise;
  logic [7:0] len_val_wave;
  logic tick_len, tick_sweep, tick_env;
  logic [2:0] step;
  logic [3:0] restart, ch_active;
  int total = 0, bad = 0;
  int n = 0;
  int m_cnt[4];
  bit [3:0] m_act = '0, m_rst = '0;

  apu_frame_sequencer #(.DIV(DIV)) dut (
    .clk_100(clk_100), .reset(reset), .apu_en(apu_en), .trig(trig), .len_wr(len_wr),
    .len_val_sq1(len_val_sq1), .len_val_sq2(len_val_sq2), .len_val_wave(len_val_wave),
    .len_val_noise(len_val_noise), .len_en(len_en), .dac_on(dac_on), .sweep_ovf(sweep_ovf),
    .tick_len(tick_len), .tick_sweep(tick_sweep), .tick_env(tick_env), .step(step),
    .restart(restart), .ch_active(ch_active));

  always #5 clk_100 = ~clk_100;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // n = enabled clock edges since enable; the k-th DIV boundary completes step k-1.
  function automatic bit m_tl(int k);
    return k > 0 && k % DIV == 0 && (k / DIV) % 2 == 1;
  endfunction
  function automatic bit m_ts(int k);
    return k > 0 && k % DIV == 0 && (k / DIV) % 4 == 3;
  endfunction
  function automatic bit m_te(int k);
    return k > 0 && k % DIV == 0 && (k / DIV) % 8 == 0;
  endfunction

  task automatic m_reset();
    n = 0;
    m_act = '0;
    m_rst = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic m_update();
    bit tl;
    tl = m_tl(n);
    if (!apu_en) begin
      m_reset();
      return;
    end
    n++;
    m_rst = trig;
    for (int i = 0; i < 4; i++) begin
      int mx, v;
      bit ex;
      mx = (i == 2) ? 256 : 64;
      v = (i == 0) ? int'(len_val_sq1) : (i == 1) ? int'(len_val_sq2) :
          (i == 2) ? int'(len_val_wave) : int'(len_val_noise);
      ex = 0;
      if (len_wr[i]) m_cnt[i] = mx - v;
      else if (trig[i]) begin
        if (m_cnt[i] == 0) m_cnt[i] = mx;
      end else if (tl && len_en[i] && m_cnt[i] > 0) begin
        m_cnt[i]--;
        ex = (m_cnt[i] == 0);
      end
      if (!dac_on[i] || ex || (i == 0 && sweep_ovf)) m_act[i] = 0;
      else if (trig[i]) m_act[i] = 1;
    end
  endtask

  task automatic check_outs();
    chk("step", step, (n / DIV) % 8);
    chk("tick_len", tick_len, m_tl(n));
    chk("tick_sweep", tick_sweep, m_ts(n));
    chk("tick_env", tick_env, m_te(n));
    chk("restart", restart, m_rst);
    chk("ch_active", ch_active, m_act);
  endtask

  task automatic clk_step();
    @(posedge clk_100);
    if (reset) m_reset();
    else m_update();
    #1;
    check_outs();
  endtask

  task automatic clear_strobes();
    trig = '0;
    len_wr = '0;
    sweep_ovf = 1'b0;
  endtask

  // Counts tick_len pulses (from the current cycle on) until ch_active[ch] falls.
  task automatic ticks_until_drop(int ch, int budget, output int cnt);
    int c;
    cnt = tick_len;
    for (c = 0; c < budget && ch_active[ch]; c++) begin
      clk_step();
      if (tick_len) cnt++;
    end
    if (c >= budget) chk("drop_timeout", ch_active[ch], 0);
  endtask

  initial begin
    int cl, cs, ce, c;
    bit env_seen;
    reset = 1'b1;
    apu_en = 1'b0;
    clear_strobes();
    len_en = '0;
    dac_on = '0;
    len_val_sq1 = '0;
    len_val_sq2 = '0;
    len_val_wave = '0;
    len_val_noise = '0;
    m_reset();
    repeat (2) clk_step();
    reset = 1'b0;
    clk_step();

    // Step sequence and strobe counts over 64 enabled cycles.
    apu_en = 1'b1;
    cl = 0; cs = 0; ce = 0; env_seen = 0;
    repeat (64) begin
      clk_step();
      cl += tick_len;
      cs += tick_sweep;
      ce += tick_env;
      if (tick_env && !env_seen) begin
        env_seen = 1;
        chk("env_after_step0", step, 0);
      end
    end
    chk("cnt_len", cl, 8);
    chk("cnt_sweep", cs, 4);
    chk("cnt_env", ce, 2);

    // Square2 loaded to 2, triggered: drops on the second length tick.
    dac_on = 4'hF;
    len_en = 4'b0010;
    len_val_sq2 = 6'd62;
    len_wr = 4'b0010;
    clk_step();
    clear_strobes();
    trig = 4'b0010;
    clk_step();
    clear_strobes();
    chk("sq2_restart", restart[1], 1);
    chk("sq2_active", ch_active[1], 1);
    ticks_until_drop(1, 200, c);
    chk("sq2_ticks", c, 2);

    // Wave triggered from zero reloads to 256.
    len_en = 4'b0110;
    trig = 4'b0100;
    clk_step();
    clear_strobes();
    ticks_until_drop(2, 3000, c);
    chk("wave_ticks", c, 256);

    // DAC off blocks activation but not restart; sweep overflow kills square1.
    dac_on = 4'b1110;
    trig = 4'b0001;
    clk_step();
    clear_strobes();
    chk("dacoff_restart", restart[0], 1);
    chk("dacoff_active", ch_active[0], 0);
    dac_on = 4'hF;
    trig = 4'b0001;
    clk_step();
    clear_strobes();
    chk("sq1_active", ch_active[0], 1);
    sweep_ovf = 1'b1;
    clk_step();
    clear_strobes();
    chk("sq1_ovf", ch_active[0], 0);

    // Noise length written in a tick cycle: 54 with no decrement that cycle.
    for (c = 0; c < 20 && !m_tl(n); c++) clk_step();
    chk("tick_wait", tick_len, 1);
    len_en = 4'b1000;
    len_val_noise = 6'd10;
    len_wr = 4'b1000;
    trig = 4'b1000;
    clk_step();
    clear_strobes();
    ticks_until_drop(3, 1000, c);
    chk("noise_ticks", c, 54);

    // Disable mid-step, ignore writes while off, re-enable from step 0.
    trig = 4'b0111;
    clk_step();
    clear_strobes();
    repeat (3) clk_step();
    apu_en = 1'b0;
    clk_step();
    chk("off_active", ch_active, 0);
    chk("off_step", step, 0);
    trig = 4'hF;
    len_wr = 4'hF;
    clk_step();
    clear_strobes();
    chk("off_restart", restart, 0);
    chk("off_trig_active", ch_active, 0);
    apu_en = 1'b1;
    c = 0;
    do begin
      clk_step();
      c++;
      if (c == 1) chk("reen_step", step, 0);
    end while (!tick_len && c < 50);
    chk("reen_first_tick", c, DIV);

    // Asynchronous reset between edges.
    trig = 4'b0110;
    clk_step();
    clear_strobes();
    #2 reset = 1'b1;
    #1;
    m_reset();
    check_outs();
    clk_step();
    reset = 1'b0;
    clk_step();
    chk("post_reset_len", tick_len, 0);

    // Randomized traffic.
    len_en = 4'hF;
    repeat (2500) begin
      apu_en = ($urandom_range(0, 299) != 0);
      trig = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      len_wr = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      len_val_sq1 = 6'($urandom_range(40, 63));
      len_val_sq2 = 6'($urandom);
      len_val_wave = 8'($urandom_range(200, 255));
      len_val_noise = 6'($urandom_range(50, 63));
      if ($urandom_range(0, 19) == 0) len_en = 4'($urandom);
      dac_on = ~(4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom));
      sweep_ovf = ($urandom_range(0, 49) == 0);
      clk_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
